packet_input_fifo: RTL and testbench
====================================

PACKET_INPUT_FIFO -- requirements
Module: packet_input_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one stream beat.
REQ-002 Parameter DEPTH, default 16 (power of two): number of beat entries stored.
REQ-003 Ports SHALL be as follows, with clock and reset first:
- clk  in  1  system clock; all state updates on its rising edge.
- n_rst  in  1  asynchronous reset, active-low.
- in_data  in  DATA_WIDTH  inbound Ethernet stream beat.
- in_valid  in  1  in_data is valid this cycle.
- in_sop  in  1  beat is the first of a packet.
- in_eop  in  1  beat is the last of a packet.
- in_error  in  1  packet is bad; qualified by in_valid.
- rdreq  in  1  controller read request for one committed beat.
- out_data  out  DATA_WIDTH  beat returned for the previous accepted rdreq.
- fifo_eop  out  1  out_data is the last beat of its packet.
- eop  out  1  one-cycle pulse: a complete good packet has been committed.
- error  out  1  one-cycle pulse: a packet was discarded.
- empty  out  1  no committed beats are available to read.
- avail  out  log2(DEPTH)+1  count of committed, unread beats.

Function
REQ-004 Inbound stream SHALL have no backpressure; every valid beat is handled the same cycle.
REQ-005 Storage SHALL be a DEPTH-entry circular RAM; each entry holds {eop flag, data}.
REQ-006 Pointers wr_ptr, commit_ptr and rd_ptr SHALL each be log2(DEPTH)+1 bits; the MSB is a wrap bit and pointers wrap modulo 2*DEPTH.
REQ-007 full SHALL be true when wr_ptr - rd_ptr == DEPTH.
REQ-008 avail SHALL equal commit_ptr - rd_ptr, and empty SHALL equal (avail == 0).
REQ-009 Write FSM states SHALL be IDLE, RECEIVE and DROP.
REQ-010 IDLE:
- in_valid with in_sop=0: beat is ignored.
- in_valid with in_sop=1: beat is written and the FSM goes to RECEIVE.
- If in_eop is also 1 on that beat, it is committed immediately and the FSM stays in IDLE.
REQ-011 RECEIVE, each in_valid beat is written with its in_eop flag; on in_eop=1 with in_error=0, commit_ptr <= wr_ptr+1, eop pulses next cycle, and the FSM goes to IDLE.
REQ-012 RECEIVE, in_sop=1 on a beat: the partial packet is discarded, error pulses, and the new beat starts a fresh packet (FSM stays in RECEIVE).
REQ-013 RECEIVE, in_valid with in_error=1:
- wr_ptr <= commit_ptr (rewind) and error pulses.
- FSM goes to IDLE if in_eop=1 on that beat, else to DROP.
REQ-014 Overflow (in_valid while full, in IDLE-with-sop or RECEIVE): the beat is not written, the packet is rewound as in REQ-013, and error pulses.
REQ-015 DROP: all beats are discarded; in_valid with in_eop=1 returns the FSM to IDLE.
REQ-016 eop and error SHALL be registered one-cycle pulses and are never asserted together.
REQ-017 Read side:
- rdreq while avail > 0 is accepted: the entry at rd_ptr is captured into out_data/fifo_eop on the next rising edge (1-cycle latency) and rd_ptr increments.
- out_data/fifo_eop hold their value until the next accepted read.
REQ-018 rdreq while avail == 0 SHALL be ignored; pointers and outputs are unchanged.
REQ-019 Uncommitted beats SHALL never be readable; a read and a write/commit in the same cycle both take effect.
REQ-020 A rewind SHALL never move wr_ptr behind rd_ptr, since commit_ptr >= rd_ptr always.

Reset
REQ-021 On n_rst=0, asynchronously:
- all pointers are 0 and the FSM is IDLE.
- out_data=0, fifo_eop=0, eop=0, error=0, empty=1, avail=0.
REQ-022 RAM contents need no reset.
REQ-023 Reset mid-packet SHALL discard all stored data.

Verification
REQ-024 4-beat packet 0x11..0x44 (sop on beat 1, eop on beat 4) -> eop pulses once; avail=4; four rdreqs return 0x11,0x22,0x33,0x44 with fifo_eop=1 only on 0x44; then empty=1.
REQ-025 3-beat packet with in_error on beat 3 -> error pulse; avail stays 0; wr_ptr equals its value before the packet.
REQ-026 Committed 2-beat packet, then a 20-beat packet with DEPTH=16 -> error pulse at overflow; DROP until eop; avail=2; the first packet reads back intact.
REQ-027 Single beat with in_sop=in_eop=1 (0xAB) -> eop pulse; avail=1; one rdreq -> out_data=0xAB, fifo_eop=1.
REQ-028 rdreq held high with avail=0, then a 1-beat packet arrives -> no read before commit; exactly one read after commit; avail returns to 0.
REQ-029 Wrap test: 40 one-beat packets, interleaving writes and reads -> data order is preserved across pointer wrap and full/empty flags are correct at every step.

Source files
------------

// File: rtl/packet_input_fifo.sv
// ---------------------------------------------------------------------------
// packet_input_fifo
//
// Packet-aware input FIFO for an inbound Ethernet beat stream. Beats are
// written as they arrive (the stream cannot be stalled). They become
// readable only once the whole packet has arrived cleanly. A bad packet,
// a packet that overflows the buffer, or a packet cut short by a new
// start-of-packet is discarded by rewinding the write pointer to the last
// commit point.
//
// Ports
//   clk       : system clock, rising edge
//   n_rst     : asynchronous active-low reset
//   in_data   : inbound beat
//   in_valid  : in_data valid this cycle
//   in_sop    : first beat of a packet
//   in_eop    : last beat of a packet
//   in_error  : packet is bad (qualified by in_valid)
//   rdreq     : read one committed beat
//   out_data  : beat returned for the previous accepted rdreq (held)
//   fifo_eop  : out_data is the last beat of its packet (held)
//   eop       : one-cycle pulse, a good packet was committed
//   error     : one-cycle pulse, a packet was discarded
//   empty     : no committed beats available
//   avail     : number of committed, unread beats
//
// Handshake: the inbound side has no ready; every in_valid beat is consumed
// in the cycle it is presented. On the read side a request is accepted in
// any cycle where rdreq=1 and avail>0; the beat appears on out_data after
// the next rising edge and stays there until the next accepted read.
//
// The write FSM state is held in state_q (enum state_t) for checkers to
// bind to.
// ---------------------------------------------------------------------------
module packet_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_valid,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic                    in_error,
  input  logic                    rdreq,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    fifo_eop,
  output logic                    eop,
  output logic                    error,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  avail
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  fifo_eop_q, fifo_eop_d;
  logic                  eop_q, eop_d;
  logic                  error_q, error_d;

  // Each entry is {eop flag, data}.
  logic [DATA_WIDTH:0]   mem [DEPTH];

  // Per-cycle decode shared by the next-state and output processes.
  logic                  restart;
  logic                  in_pkt;
  logic                  full_now;
  logic                  bad_beat;
  logic                  wr_en;
  logic                  commit_en;
  logic                  rd_en;
  logic [PW-1:0]         wr_base;

  always_comb begin
    // A sop while receiving abandons the partial packet: the new beat is
    // written at the commit point, so fullness is judged from there.
    restart   = in_valid && in_sop && (state_q == ST_RECEIVE);
    wr_base   = restart ? commit_ptr_q : wr_ptr_q;
    // Fullness is judged against rd_ptr before any same-cycle read.
    full_now  = ((wr_base - rd_ptr_q) == PW'(DEPTH));
    in_pkt    = in_valid && (((state_q == ST_IDLE) && in_sop) ||
                             (state_q == ST_RECEIVE));
    bad_beat  = in_pkt && (in_error || full_now);
    wr_en     = in_pkt && !bad_beat;
    commit_en = wr_en && in_eop;
    rd_en     = rdreq && (commit_ptr_q != rd_ptr_q);
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RECEIVE: begin
        if (in_pkt) begin
          if (in_eop)        state_d = ST_IDLE;
          else if (bad_beat) state_d = ST_DROP;
          else               state_d = ST_RECEIVE;
        end
      end
      ST_DROP: begin
        if (in_valid && in_eop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    out_data_d   = out_data_q;
    fifo_eop_d   = fifo_eop_q;
    // A restart that also carries eop commits the new one-beat packet but
    // reports only the discard, so eop and error never pulse together.
    error_d      = restart || bad_beat;
    eop_d        = commit_en && !restart;

    if (bad_beat)   wr_ptr_d = commit_ptr_q;
    else if (wr_en) wr_ptr_d = wr_base + PW'(1);

    if (commit_en)  commit_ptr_d = wr_base + PW'(1);

    // Only committed entries are read, and writes only land beyond the
    // commit point, so a same-cycle write never aliases this read.
    if (rd_en) begin
      rd_ptr_d                 = rd_ptr_q + PW'(1);
      {fifo_eop_d, out_data_d} = mem[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      out_data_q   <= '0;
      fifo_eop_q   <= 1'b0;
      eop_q        <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      out_data_q   <= out_data_d;
      fifo_eop_q   <= fifo_eop_d;
      eop_q        <= eop_d;
      error_q      <= error_d;
    end
  end

  // Storage needs no reset: nothing is readable until committed.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_base[AW-1:0]] <= {in_eop, in_data};
  end

  assign out_data = out_data_q;
  assign fifo_eop = fifo_eop_q;
  assign eop      = eop_q;
  assign error    = error_q;
  assign avail    = commit_ptr_q - rd_ptr_q;
  assign empty    = (avail == '0);

endmodule

// File: tb/tb_packet_input_fifo.sv
// ---------------------------------------------------------------------------
// tb_packet_input_fifo
//
// Directed bench for packet_input_fifo (DATA_WIDTH=32, DEPTH=16). A
// queue-based packet model predicts every output each cycle; literal
// expectations at key points pin the model to hand-derived values.
// Inputs change 1 time unit after a rising edge; outputs are compared on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_packet_input_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] in_data  = '0;
  logic          in_valid = 1'b0;
  logic          in_sop   = 1'b0;
  logic          in_eop   = 1'b0;
  logic          in_error = 1'b0;
  logic          rdreq    = 1'b0;
  logic [DW-1:0] out_data;
  logic          fifo_eop;
  logic          eop;
  logic          error;
  logic          empty;
  logic [CW-1:0] avail;

  packet_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sop   (in_sop),
    .in_eop   (in_eop),
    .in_error (in_error),
    .rdreq    (rdreq),
    .out_data (out_data),
    .fifo_eop (fifo_eop),
    .eop      (eop),
    .error    (error),
    .empty    (empty),
    .avail    (avail)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // committed beats awaiting read, and the beats of the packet in flight
  logic [DW:0]   exp_q[$];
  logic [DW:0]   pend_q[$];
  int            mode = 0;      // 0: between packets, 1: in a packet, 2: discarding
  logic [DW-1:0] m_out  = '0;
  logic          m_feop = 1'b0;
  logic          m_eop  = 1'b0;
  logic          m_err  = 1'b0;

  always @(posedge clk or negedge n_rst) begin
    int          stored;
    logic        restart;
    logic [DW:0] e;
    if (!n_rst) begin
      exp_q.delete();
      pend_q.delete();
      mode   = 0;
      m_out  = '0;
      m_feop = 1'b0;
      m_eop  = 1'b0;
      m_err  = 1'b0;
    end else begin
      stored  = exp_q.size();
      restart = 1'b0;
      m_eop   = 1'b0;
      m_err   = 1'b0;
      if (rdreq && exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        m_out  = e[DW-1:0];
        m_feop = e[DW];
      end
      if (in_valid) begin
        if (mode == 2) begin
          if (in_eop) mode = 0;
        end else if (mode == 1 || in_sop) begin
          if (mode == 1 && in_sop) begin
            pend_q.delete();
            restart = 1'b1;
            m_err   = 1'b1;
          end
          if (in_error || (stored + pend_q.size() == DEPTH)) begin
            pend_q.delete();
            m_err = 1'b1;
            mode  = in_eop ? 0 : 2;
          end else begin
            pend_q.push_back({in_eop, in_data});
            if (in_eop) begin
              foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
              pend_q.delete();
              m_eop = !restart;
              mode  = 0;
            end else begin
              mode = 1;
            end
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("out_data", out_data, m_out);
    check("fifo_eop", fifo_eop, m_feop);
    check("eop",      eop,      m_eop);
    check("error",    error,    m_err);
    check("avail",    avail,    exp_q.size());
    check("empty",    empty,    exp_q.size() == 0);
    check("eop_error_excl", eop & error, 1'b0);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic sop, input logic e_op,
                       input logic err, input logic [DW-1:0] d, input logic rd);
    in_valid = v;
    in_sop   = sop;
    in_eop   = e_op;
    in_error = err;
    in_data  = d;
    rdreq    = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic sop, input logic e_op, input logic err, input logic [DW-1:0] d);
    drive(1'b1, sop, e_op, err, d, 1'b0);
  endtask

  task automatic read1();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_avail", avail, 0);
    check("rst_empty", empty, 1);
    check("rst_out_data", out_data, 0);
    check("rst_eop", eop, 0);
    check("rst_error", error, 0);
    n_rst = 1'b1;
    idle(2);

    // 4-beat good packet
    beat(1, 0, 0, 32'h11);
    beat(0, 0, 0, 32'h22);
    beat(0, 0, 0, 32'h33);
    beat(0, 1, 0, 32'h44);
    check("p4_eop", eop, 1);
    check("p4_avail", avail, 4);
    read1(); check("p4_rd0", {fifo_eop, out_data}, {1'b0, 32'h11});
    read1(); check("p4_rd1", {fifo_eop, out_data}, {1'b0, 32'h22});
    read1(); check("p4_rd2", {fifo_eop, out_data}, {1'b0, 32'h33});
    read1(); check("p4_rd3", {fifo_eop, out_data}, {1'b1, 32'h44});
    check("p4_empty", empty, 1);
    check("p4_eop_once", eop, 0);
    idle(1);

    // 3-beat packet flagged bad on its last beat
    beat(1, 0, 0, 32'h51);
    beat(0, 0, 0, 32'h52);
    beat(0, 1, 1, 32'h53);
    check("bad_error", error, 1);
    check("bad_avail", avail, 0);
    check("bad_wr_ptr", dut.wr_ptr_q, 4);
    idle(1);

    // beat without sop outside a packet is ignored
    beat(0, 1, 0, 32'h99);
    check("nosop_avail", avail, 0);
    check("nosop_eop", eop, 0);

    // single-beat packet
    beat(1, 1, 0, 32'hAB);
    check("one_eop", eop, 1);
    check("one_avail", avail, 1);
    read1();
    check("one_rd", {fifo_eop, out_data}, {1'b1, 32'hAB});
    idle(1);

    // committed 2-beat packet, then a 20-beat packet that overflows
    beat(1, 0, 0, 32'hC1);
    beat(0, 1, 0, 32'hC2);
    check("ovf_pre_avail", avail, 2);
    for (int k = 1; k <= 20; k++) begin
      beat(k == 1, k == 20, 0, 32'hD00 + k);
      if (k == 14) check("ovf_no_err_yet", error, 0);
      if (k == 15) check("ovf_error", error, 1);
    end
    check("ovf_drop_no_eop", eop, 0);
    check("ovf_avail", avail, 2);
    read1(); check("ovf_rd0", {fifo_eop, out_data}, {1'b0, 32'hC1});
    read1(); check("ovf_rd1", {fifo_eop, out_data}, {1'b1, 32'hC2});

    // rdreq held while empty, then a packet arrives
    for (int i = 0; i < 3; i++) read1();
    check("hold_out", out_data, 32'hC2);
    drive(1, 1, 1, 0, 32'hE5, 1);
    check("hold_commit_eop", eop, 1);
    check("hold_no_early_read", out_data, 32'hC2);
    check("hold_avail1", avail, 1);
    read1();
    check("hold_rd", out_data, 32'hE5);
    check("hold_avail0", avail, 0);
    read1();
    check("hold_no_extra", out_data, 32'hE5);
    idle(1);

    // sop inside a packet restarts it
    beat(1, 0, 0, 32'h61);
    beat(0, 0, 0, 32'h62);
    beat(1, 0, 0, 32'h63);
    check("restart_error", error, 1);
    beat(0, 1, 0, 32'h64);
    check("restart_eop", eop, 1);
    check("restart_avail", avail, 2);
    read1(); check("restart_rd0", {fifo_eop, out_data}, {1'b0, 32'h63});
    read1(); check("restart_rd1", {fifo_eop, out_data}, {1'b1, 32'h64});

    // reset in the middle of a packet
    beat(1, 1, 0, 32'h70);
    beat(1, 0, 0, 32'h71);
    beat(0, 0, 0, 32'h72);
    n_rst = 1'b0;
    #1;
    check("mid_rst_avail", avail, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_out", out_data, 0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    beat(0, 1, 0, 32'h73);
    check("post_rst_avail", avail, 0);
    check("post_rst_eop", eop, 0);

    // wrap: 40 one-beat packets, first 20 without reads (4 overflow),
    // then 20 with a read in the same cycle, then drain
    for (int i = 0; i < 20; i++) beat(1, 1, 0, 32'h1000 + i);
    check("wrap_full_avail", avail, 16);
    check("wrap_full_error", error, 1);
    for (int i = 20; i < 40; i++) drive(1, 1, 1, 0, 32'h1000 + i, 1);
    check("wrap_mid_avail", avail, 15);
    for (int i = 0; i < 18; i++) read1();
    check("wrap_last", {fifo_eop, out_data}, {1'b1, 32'h1027});
    check("wrap_empty", empty, 1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
